// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-speed scheduler: phase encoding,
// level width and the width helper every counter is sized with.
package snake_pkg;

    localparam int LEVEL_W  = 4;
    localparam int MS_PER_S = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler: one-cycle ms_stb every DIV enabled cycles.
// Holds its phase while en is low; clr restarts the millisecond from zero.
module ms_prescaler
    import snake_pkg::*;
#(
    parameter int DIV = 65_000
) (
    input  logic clk65MHz,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ms_stb
);

    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign ms_stb = en && (cnt_q == TERM);

    // NOTE: every path starts from the held value, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ms_stb) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment; reset is sampled on the clock edge.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/move_tick_ctrl.sv
// Snake game-speed scheduler: game phase FSM, speed level and move_tick strobe.
// Optional `TICK_BOOST_EN adds a boost input that halves newly latched periods.
module move_tick_ctrl
    import snake_pkg::*;
#(
    parameter int CLK_FREQ  = 65_000_000,
    parameter int BASE_MS   = 200,
    parameter int STEP_MS   = 10,
    parameter int MIN_MS    = 50,
    parameter int MAX_LEVEL = 15
) (
    input  logic               clk65MHz,
    input  logic               rst,
    input  logic               start,
    input  logic               pause_toggle,
    input  logic               game_over,
    input  logic               speed_up,
`ifdef TICK_BOOST_EN
    input  logic               boost,
`endif
    output logic               move_tick,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         state,
    output logic               running
);

    localparam int MS_DIV = CLK_FREQ / MS_PER_S;
    localparam int PER_W  = clog2(BASE_MS + 1);

    typedef logic [PER_W-1:0] per_t;

    localparam per_t               BASE_P  = per_t'(BASE_MS);
    localparam per_t               MIN_P   = per_t'(MIN_MS);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    per_t               period_q, period_d;
    per_t               ms_cnt_q, ms_cnt_d;
    logic               move_tick_q, move_tick_d;

    logic               ms_stb;
    logic               start_run;
    logic               tick_cond;
    logic [LEVEL_W-1:0] lvl_sel;
    per_t               period_nom;
    per_t               period_sel;

    ms_prescaler #(
        .DIV (MS_DIV)
    ) u_prescaler (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .en       (state_q == ST_RUN),
        .clr      (start_run),
        .ms_stb   (ms_stb)
    );

    // Reduction is compared before subtracting so the period never underflows.
    function automatic per_t period_of(input logic [LEVEL_W-1:0] lvl);
        int red;
        red = int'(lvl) * STEP_MS;
        if (red + MIN_MS >= BASE_MS) begin
            return MIN_P;
        end
        return per_t'(BASE_MS - red);
    endfunction

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (pause_toggle) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (pause_toggle) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh game always starts at level 0, whatever level_q still holds.
    always_comb begin
        lvl_sel    = start_run ? '0 : level_q;
        period_nom = period_of(lvl_sel);
`ifdef TICK_BOOST_EN
        if (boost) begin
            period_sel = ((period_nom >> 1) < MIN_P) ? MIN_P : (period_nom >> 1);
        end else begin
            period_sel = period_nom;
        end
`else
        period_sel = period_nom;
`endif
    end

    always_comb begin
        tick_cond = ms_stb && (ms_cnt_q == period_q - per_t'(1));

        ms_cnt_d = ms_cnt_q;
        if (start_run || tick_cond) begin
            ms_cnt_d = '0;
        end else if (ms_stb) begin
            ms_cnt_d = ms_cnt_q + per_t'(1);
        end

        // Level changes only reach the period at the next latch point.
        period_d = period_q;
        if (start_run || tick_cond) begin
            period_d = period_sel;
        end

        // A tick coinciding with leaving RUN is dropped so it never lands outside RUN.
        move_tick_d = tick_cond && (state_d == ST_RUN);

        level_d = level_q;
        if (start_run) begin
            level_d = '0;
        end else if ((state_q == ST_RUN || state_q == ST_PAUSE) && speed_up &&
                     !game_over && (level_q != MAX_LVL)) begin
            level_d = level_q + LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            period_q    <= BASE_P;
            ms_cnt_q    <= '0;
            move_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            period_q    <= period_d;
            ms_cnt_q    <= ms_cnt_d;
            move_tick_q <= move_tick_d;
        end
    end

    assign move_tick = move_tick_q;
    assign level     = level_q;
    assign state     = state_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_move_tick_ctrl.sv
// Directed bench for move_tick_ctrl at 65 cycles/ms: vector table for the
// phase/level logic, hand-written sequences for tick timing corner cases.
module tb_move_tick_ctrl;

    localparam int CLK_FREQ = 65_000;

    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_RST   = 5'b10000;
    localparam logic [4:0] I_START = 5'b01000;
    localparam logic [4:0] I_PAUSE = 5'b00100;
    localparam logic [4:0] I_GO    = 5'b00010;
    localparam logic [4:0] I_SU    = 5'b00001;

    logic       clk65MHz = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause_toggle = 1'b0;
    logic       game_over = 1'b0;
    logic       speed_up = 1'b0;
`ifdef TICK_BOOST_EN
    logic       boost = 1'b0;
`endif
    logic       move_tick;
    logic [3:0] level;
    logic [1:0] state;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk65MHz = ~clk65MHz;

    move_tick_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .BASE_MS   (200),
        .STEP_MS   (10),
        .MIN_MS    (50),
        .MAX_LEVEL (15)
    ) dut (
        .clk65MHz     (clk65MHz),
        .rst          (rst),
        .start        (start),
        .pause_toggle (pause_toggle),
        .game_over    (game_over),
        .speed_up     (speed_up),
`ifdef TICK_BOOST_EN
        .boost        (boost),
`endif
        .move_tick    (move_tick),
        .level        (level),
        .state        (state),
        .running      (running)
    );

    typedef struct packed {
        logic [4:0] stim;
        logic [1:0] exp_state;
        logic [3:0] exp_level;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock edge with the given pulses applied; outputs are settled on return.
    task automatic drive_cycle(input logic [4:0] v);
        {rst, start, pause_toggle, game_over, speed_up} = v;
        @(posedge clk65MHz);
        #1;
        {rst, start, pause_toggle, game_over, speed_up} = I_NONE;
    endtask

    task automatic run_edges(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(posedge clk65MHz);
            #1;
            if (move_tick) ticks++;
        end
    endtask

    // Edges until move_tick is seen high; -1 if the budget runs out.
    task automatic wait_tick(input int budget, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            @(posedge clk65MHz);
            #1;
            n++;
            if (move_tick) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    task automatic check_outputs(input string tag, input int st, input int lv);
        check({tag, "_state"}, int'(state), st);
        check({tag, "_level"}, int'(level), lv);
        check({tag, "_running"}, int'(running), (st == 1) ? 1 : 0);
        check({tag, "_tick"}, int'(move_tick), 0);
    endtask

    initial begin
        int n;
        int t;

        vecs[0]  = '{I_RST,                    2'd0, 4'd0};
        vecs[1]  = '{I_SU,                     2'd0, 4'd0};
        vecs[2]  = '{I_PAUSE,                  2'd0, 4'd0};
        vecs[3]  = '{I_GO,                     2'd0, 4'd0};
        vecs[4]  = '{I_START,                  2'd1, 4'd0};
        vecs[5]  = '{I_SU,                     2'd1, 4'd1};
        vecs[6]  = '{I_START | I_SU,           2'd1, 4'd2};
        vecs[7]  = '{I_PAUSE | I_SU,           2'd2, 4'd3};
        vecs[8]  = '{I_SU,                     2'd2, 4'd4};
        vecs[9]  = '{I_START,                  2'd2, 4'd4};
        vecs[10] = '{I_GO | I_SU | I_PAUSE,    2'd3, 4'd4};
        vecs[11] = '{I_SU,                     2'd3, 4'd4};
        vecs[12] = '{I_PAUSE,                  2'd3, 4'd4};
        vecs[13] = '{I_START | I_PAUSE,        2'd1, 4'd0};
        vecs[14] = '{I_PAUSE,                  2'd2, 4'd0};
        vecs[15] = '{I_PAUSE | I_START,        2'd1, 4'd0};
        vecs[16] = '{I_GO | I_START,           2'd3, 4'd0};
        vecs[17] = '{I_START,                  2'd1, 4'd0};
        vecs[18] = '{I_RST | I_START | I_SU,   2'd0, 4'd0};
        vecs[19] = '{I_START,                  2'd1, 4'd0};
        vecs[20] = '{I_RST,                    2'd0, 4'd0};

        drive_cycle(I_RST);
        drive_cycle(I_RST);
        check_outputs("reset", 0, 0);

        for (int i = 0; i < 21; i++) begin
            drive_cycle(vecs[i].stim);
            check_outputs($sformatf("vec%0d", i), int'(vecs[i].exp_state),
                          int'(vecs[i].exp_level));
        end

        // First tick 200 ms after start, later periods follow the level.
        drive_cycle(I_START);
        check_outputs("start", 1, 0);
        wait_tick(13100, n);
        check("first_tick_delay", n, 13000);

        run_edges(3000, t);
        repeat (3) drive_cycle(I_SU);
        check("mid_period_stray_ticks", t, 0);
        check("level_after_3_su", int'(level), 3);
        wait_tick(10100, n);
        check("period_unchanged_by_su", n, 13000 - 3003);

        run_edges(100, t);
        repeat (20) drive_cycle(I_SU);
        check("level_saturated", int'(level), 15);
        wait_tick(11100, n);
        check("period_170ms", n, 11050 - 120);
        wait_tick(3300, n);
        check("period_min_50ms", n, 3250);

        // game_over on the tick edge swallows the tick.
        run_edges(3249, t);
        check("pre_go_stray_ticks", t, 0);
        drive_cycle(I_GO);
        check_outputs("go_on_tick", 3, 15);
        run_edges(100, t);
        check("over_no_ticks", t, 0);
        drive_cycle(I_START);
        check_outputs("restart", 1, 0);
        wait_tick(13100, n);
        check("restart_tick_delay", n, 13000);

        // Pause 5000 edges into a period; prescaler phase is held.
        run_edges(4999, t);
        drive_cycle(I_PAUSE);
        check_outputs("paused", 2, 0);
        run_edges(10000, t);
        check("pause_no_ticks", t, 0);
        check("pause_held_state", int'(state), 2);
        drive_cycle(I_PAUSE);
        check("resume_state", int'(state), 1);
        wait_tick(8100, n);
        check("resume_tick_delay", n, 8000);

        // Reset mid-period leaves nothing pending.
        run_edges(2000, t);
        drive_cycle(I_RST);
        check_outputs("mid_run_reset", 0, 0);
        run_edges(1000, t);
        check("post_reset_no_ticks", t, 0);
        check("post_reset_state", int'(state), 0);

`ifdef TICK_BOOST_EN
        boost = 1'b1;
        drive_cycle(I_START);
        wait_tick(6600, n);
        check("boost_first_tick", n, 6500);
        wait_tick(6600, n);
        check("boost_second_tick", n, 6500);
        boost = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
